// File: rtl/dtmf_pkg.sv
// Shared definitions for the DTMF command sequencer.
// Digit codes, FSM state encoding and register offsets.
package dtmf_pkg;

    localparam logic [3:0] DTMF_STAR = 4'd10;
    localparam logic [3:0] DTMF_HASH = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_PEND    = 2'd2
    } dtmf_state_t;

    localparam logic [2:0] OFF_CTRL    = 3'd0;
    localparam logic [2:0] OFF_STATUS  = 3'd1;
    localparam logic [2:0] OFF_TIMEOUT = 3'd2;
    localparam logic [2:0] OFF_ERRCNT  = 3'd3;

    function automatic logic is_data(input logic [3:0] d);
        return (d != DTMF_STAR) && (d != DTMF_HASH);
    endfunction

endpackage

// File: rtl/dtmf_tick_gen.sv
// Free-running prescaler: one-clock tick strobe every TICK_DIV clocks.
// Ports: clk, reset (sync, active-high), tick (strobe out).
module dtmf_tick_gen #(
    parameter int TICK_DIV = 48000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + W'(1);
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/dtmf_cmd_sequencer.sv
// Collects DTMF digits into a framed command and hands it over valid/ack.
// Ports: decoder in (Detect_in/Digit_in), command out (Cmd_*), Busy, reg bus.
module dtmf_cmd_sequencer
    import dtmf_pkg::*;
#(
    parameter logic [7:0] REG_BASE   = 8'h40,
    parameter int         MAX_DIGITS = 8,
    parameter int         TICK_DIV   = 48000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Detect_in,
    input  logic [3:0]  Digit_in,
    output logic        Cmd_valid,
    input  logic        Cmd_ack,
    output logic [31:0] Cmd_digits,
    output logic [3:0]  Cmd_len,
    output logic        Busy,
    input  logic        rdena,
    input  logic        wrena,
    input  logic [7:0]  reg_addr,
    input  logic [7:0]  wr_data,
    input  logic [7:0]  rd_data_in,
    output logic [7:0]  rd_data
);

    localparam logic [3:0] MAX_LEN = 4'(MAX_DIGITS);

    dtmf_state_t state, state_n;
    logic [31:0] dig_buf, buf_n;
    logic [3:0]  len, len_n;
    logic        det_q, enable;
    logic [7:0]  timeout_reg, errcnt, tcnt, off, rd_sel;
    logic        tick, evt, in_win, wr_hit;
    logic        soft_abort, err_clr, err_inc, tmo_hit, clr;

    dtmf_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );

    // Window decode relative to the base; wraps harmlessly outside it.
    assign off        = reg_addr - REG_BASE;
    assign in_win     = (off < 8'd8);
    assign wr_hit     = wrena && in_win;
    assign soft_abort = wr_hit && (off[2:0] == OFF_CTRL) && wr_data[1];
    assign err_clr    = wr_hit && (off[2:0] == OFF_ERRCNT);

    assign evt = Detect_in && !det_q && enable;

    // Fires on the TIMEOUT-th tick since the last accepted event.
    assign tmo_hit = (timeout_reg != 8'd0) && tick &&
                     (({1'b0, tcnt} + 9'd1) >= {1'b0, timeout_reg});

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            dig_buf <= '0;
            len     <= '0;
            det_q   <= 1'b0;
        end else begin
            state   <= state_n;
            dig_buf <= buf_n;
            len     <= len_n;
            det_q   <= Detect_in;
        end
    end

    always_comb begin
        state_n = state;
        buf_n   = dig_buf;
        len_n   = len;
        err_inc = 1'b0;
        clr     = 1'b0;
        if (soft_abort) begin
            clr = 1'b1;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (evt && is_data(Digit_in)) begin
                        buf_n   = {28'd0, Digit_in};
                        len_n   = 4'd1;
                        state_n = ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (evt) begin
                        if (Digit_in == DTMF_STAR) begin
                            clr = 1'b1;
                        end else if (Digit_in == DTMF_HASH) begin
                            if (len != 4'd0)
                                state_n = ST_PEND;
                        end else if (len >= MAX_LEN) begin
                            clr     = 1'b1;
                            err_inc = 1'b1;
                        end else begin
                            buf_n = dig_buf |
                                    ({28'd0, Digit_in} << {len, 2'b00});
                            len_n = len + 4'd1;
                        end
                    end else if (tmo_hit) begin
                        clr     = 1'b1;
                        err_inc = 1'b1;
                    end
                end
                ST_PEND: begin
                    err_inc = evt;
                    if (Cmd_ack)
                        clr = 1'b1;
                end
                default: clr = 1'b1;
            endcase
        end
        if (clr) begin
            state_n = ST_IDLE;
            buf_n   = '0;
            len_n   = '0;
        end
    end

    // Inter-digit tick counter, held at zero outside COLLECT.
    always_ff @(posedge clk) begin
        if (reset || state != ST_COLLECT || evt)
            tcnt <= '0;
        else if (tick && tcnt != 8'hFF)
            tcnt <= tcnt + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            enable      <= 1'b1;
            timeout_reg <= 8'd200;
            errcnt      <= '0;
        end else begin
            if (wr_hit && off[2:0] == OFF_CTRL)
                enable <= wr_data[0];
            if (wr_hit && off[2:0] == OFF_TIMEOUT)
                timeout_reg <= wr_data;
            if (err_clr)
                errcnt <= '0;
            else if (err_inc && errcnt != 8'hFF)
                errcnt <= errcnt + 8'd1;
        end
    end

    always_comb begin
        rd_sel = 8'h00;
        unique case (off[2:0])
            3'd0:    rd_sel = {7'd0, enable};
            3'd1:    rd_sel = {len, 2'b00, state};
            3'd2:    rd_sel = timeout_reg;
            3'd3:    rd_sel = errcnt;
            3'd4:    rd_sel = dig_buf[7:0];
            3'd5:    rd_sel = dig_buf[15:8];
            3'd6:    rd_sel = dig_buf[23:16];
            3'd7:    rd_sel = dig_buf[31:24];
            default: rd_sel = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            rd_data <= '0;
        else if (rdena && in_win)
            rd_data <= rd_sel;
        else
            rd_data <= rd_data_in;
    end

    assign Cmd_valid  = (state == ST_PEND);
    assign Busy       = (state != ST_IDLE);
    assign Cmd_digits = dig_buf;
    assign Cmd_len    = len;

endmodule

// File: doc/dtmf_cmd_sequencer.md
# dtmf_cmd_sequencer

Collects validated DTMF digits from the DTMF decoder into a command string, frames it with `*` (abort) and `#` (execute) plus an inter-digit timeout, and hands complete commands to the MicroSequencer over a valid/ack handshake. Sits between the decoder's `Detect_out`/`Detect_digit` outputs and the MicroSequencer. Joins the shared register bus as a link in the `rd_data_in -> rd_data` read chain.

## Interface
Parameters:
- `REG_BASE`, 8'h40, base address of an 8-register window (`REG_BASE`..`REG_BASE+7`).
- `MAX_DIGITS`, 8, command buffer depth in digits (fixed at 8 for this register map).
- `TICK_DIV`, 48000, clocks per timeout tick (1 ms at 48 MHz).

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `Detect_in` in 1: decoder digit-present level.
- `Digit_in` in 4: decoder digit code, valid while `Detect_in`=1.
- `Cmd_valid` out 1: complete command pending.
- `Cmd_ack` in 1: consumer accepts command.
- `Cmd_digits` out 32: digit i at bits [4i+3:4i], first digit in [3:0], unused nibbles 0.
- `Cmd_len` out 4: digit count, 1..8.
- `Busy` out 1: high in COLLECT or PEND.
- `rdena`, `wrena` in 1: register strobes.
- `reg_addr` in 8, `wr_data` in 8.
- `rd_data_in` in 8: upstream read data.
- `rd_data` out 8: read data.

## Operation
- Digit codes (decoder encoding): 0-9 = digits, 10 = `*`, 11 = `#`, 12-15 = A-D.
- A digit event is a rising edge of `Detect_in`. `Digit_in` is sampled on the same cycle. Held levels produce one event only.
- All events are ignored while CTRL.enable=0.
- States:
  - IDLE: a data digit (0-9, A-D) writes slot 0, len=1, goes to COLLECT. `*` and `#` are ignored.
  - COLLECT: a data digit appends. `*` clears the buffer and goes to IDLE. `#` goes to PEND if len≥1.
  - COLLECT overflow: a 9th data digit clears the buffer, increments ERRCNT, goes to IDLE.
  - COLLECT timeout: the timeout counter reaching TIMEOUT clears the buffer, increments ERRCNT, goes to IDLE. The counter restarts on every accepted event.
  - PEND: `Cmd_valid`=1, buffer frozen. Every digit event increments ERRCNT and is dropped. `Cmd_ack`=1 clears the buffer and goes to IDLE.
- TIMEOUT=0 disables the timeout.
- ERRCNT saturates at 255.
- Registers (offset from `REG_BASE`):
  - 0 CTRL R/W: bit0 enable (reset 1). Bit1 write-1 soft-abort: clears buffer and goes to IDLE from any state; reads 0.
  - 1 STATUS RO: [1:0] state (IDLE=0, COLLECT=1, PEND=2), [7:4] len.
  - 2 TIMEOUT R/W: ticks, reset 8'd200.
  - 3 ERRCNT: read returns the count; any write clears it.
  - 4-7 DIGITS RO: `Cmd_digits` bytes, byte 0 at offset 4.
- Read: if `rdena` and the address is in the window, `rd_data` returns the register. Otherwise `rd_data` passes `rd_data_in` through.

## Timing
- Reset values:
  - Outputs: `Cmd_valid`=0, `Cmd_digits`=0, `Cmd_len`=0, `Busy`=0, `rd_data`=0.
  - Internal: state IDLE, edge register 0, ERRCNT=0, tick prescaler 0.
- Event latency: `Detect_in` rising in cycle N updates the buffer and state at the end of cycle N, so outputs change in cycle N+1. `#` in cycle N gives `Cmd_valid`=1 in cycle N+1.
- Handshake: `Cmd_valid` stays high until `Cmd_ack` is sampled high. It is low in the following cycle. `Cmd_ack` outside PEND is ignored.
- Simultaneous `Cmd_ack` and digit event in PEND: the digit is dropped (ERRCNT+1), and the state goes to IDLE.
- Simultaneous soft-abort and any event: soft-abort wins. The event is discarded and not counted.
- Simultaneous ERRCNT clear and increment: clear wins.
- Timeout tick: one strobe every `TICK_DIV` clocks, free-running. Timeout fires between TIMEOUT-1 and TIMEOUT ticks after the last event.
- `rd_data` is registered: address in cycle N, data in N+1. Pass-through uses the same register stage.
- Write effects are visible on the next cycle.
- Reset mid-command: the buffer is lost, and `Cmd_valid` is low on the cycle after reset.

## Structure
- `dtmf_pkg`: digit code constants (`DTMF_STAR`=10, `DTMF_HASH`=11), state enum, register offset constants.
- Sub-module `dtmf_tick_gen`: `TICK_DIV` prescaler producing a 1-clock tick strobe, synchronous reset.
- The FSM, buffer, and register file live in the top module.

## Test plan
- Enter 1,2,3,`#`: `Cmd_valid`=1 one cycle after the `#` edge, `Cmd_digits`=32'h0000_0321, `Cmd_len`=3. Assert `Cmd_ack`: `Cmd_valid`=0 the next cycle, STATUS reads 8'h00.
- Enter 5,`*`,7,`#`: command 32'h7, len 1. Hold `Detect_in` high for 100 cycles on one digit: only one digit is stored.
- Enter 9 digits: ERRCNT=1, state IDLE, no `Cmd_valid`. Write ERRCNT: reads 0.
- `TICK_DIV`=4, TIMEOUT=3: enter 4 and wait 16 clocks. Buffer cleared, ERRCNT=1. With TIMEOUT=0, no timeout occurs after 1000 clocks.
- In PEND, send digit 6 on the same cycle as `Cmd_ack`: state IDLE, ERRCNT=1, no new command.
- Reads: `reg_addr`=REG_BASE+4 after command 8'h21 gives `rd_data`=8'h21. `reg_addr`=8'h10 with `rd_data_in`=8'hA5 gives 8'hA5 one cycle later. Reset asserted mid-COLLECT: all outputs 0 next cycle.
